// File: rtl/mem_access_ctrl_if.sv
// Request/response and byte-array bus for the memory access controller.
// The master side issues requests and supplies array read data; the slave side is the controller.
interface mem_access_ctrl_if;
  logic        req;
  logic        r_w;
  logic [1:0]  dt;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        moc;
  logic        busy;
  logic        err;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  modport master (
    output req, r_w, dt, addr, wdata, mem_rdata,
    input  rdata, moc, busy, err, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  req, r_w, dt, addr, wdata, mem_rdata,
    output rdata, moc, busy, err, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Byte-serial big-endian access controller: moves 1, 2 or 4 bytes between the
// requester and a 256x8 array, one byte per cycle, then pulses moc.
module mem_access_ctrl (
  input  logic             clk,
  input  logic             clr,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t      state, state_nx;
  logic [1:0]  cnt, cnt_nx;
  logic        lat_rw;
  logic [1:0]  lat_dt;
  logic [7:0]  lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] acc, acc_nx;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        we_q, we_nx;
  logic        illegal;
  logic        last;
  logic [1:0]  nbm1;
  logic [1:0]  idx;

  always_comb begin
    illegal = (bus.dt == 2'b11)
           || (bus.dt == 2'b01 && bus.addr[0])
           || (bus.dt == 2'b10 && bus.addr[1:0] != 2'b00);
    case (lat_dt)
      2'b00:   nbm1 = 2'd0;
      2'b01:   nbm1 = 2'd1;
      default: nbm1 = 2'd3;
    endcase
    // Big-endian: transfer k touches byte (N-1-k) of the word.
    idx  = nbm1 - cnt;
    last = (cnt == nbm1);
    acc_nx = acc;
    acc_nx[{idx, 3'b000} +: 8] = bus.mem_rdata;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    we_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req) begin
          if (illegal) begin
            state_nx = DONE;
          end else begin
            state_nx = XFER;
            we_nx    = !bus.r_w;
          end
        end
      end
      XFER: begin
        if (last) begin
          state_nx = DONE;
        end else begin
          cnt_nx = cnt + 2'd1;
          we_nx  = !lat_rw;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // mem_we is its own flop, precomputed one cycle ahead, so it never glitches.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      we_q      <= 1'b0;
      lat_rw    <= 1'b0;
      lat_dt    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      acc       <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      we_q <= we_nx;
      if (state == IDLE && bus.req) begin
        lat_rw    <= bus.r_w;
        lat_dt    <= bus.dt;
        lat_addr  <= bus.addr;
        lat_wdata <= bus.wdata;
        acc       <= '0;
        err_q     <= illegal;
      end else if (state == XFER && lat_rw) begin
        acc <= acc_nx;
        if (last) rdata_q <= acc_nx;
      end
    end
  end

  always_comb begin
    bus.mem_addr  = lat_addr + ((state == XFER) ? {6'b000000, cnt} : 8'h00);
    bus.mem_wdata = (state == XFER && !lat_rw) ? lat_wdata[{idx, 3'b000} +: 8] : '0;
    bus.mem_we    = we_q;
    bus.moc       = (state == DONE);
    bus.busy      = (state != IDLE);
    bus.err       = (state == DONE) && err_q;
    bus.rdata     = rdata_q;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl: each accepted request is expanded into a
// per-cycle list of expected outputs and checked on every falling clock edge.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic clr = 1'b1;

  mem_access_ctrl_if bus();

  mem_access_ctrl dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  bit         mem_init = 1'b1;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 37 + 5);
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  assign bus.mem_rdata = mem[bus.mem_addr];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
    end
  endtask

  typedef struct {
    logic        busy;
    logic        moc;
    logic        err;
    logic        we;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    bit          wchk;
    logic [31:0] rdata;
  } exp_t;

  exp_t        expq[$];
  bit          chk_en      = 1'b0;
  logic [7:0]  model_addr  = '0;
  logic [31:0] model_rdata = '0;

  function automatic exp_t mk(logic b, logic m, logic e, logic w, logic [7:0] a,
                              logic [7:0] wd, bit wc, logic [31:0] rd);
    exp_t r;
    r.busy = b; r.moc = m; r.err = e; r.we = w;
    r.addr = a; r.wdata = wd; r.wchk = wc; r.rdata = rd;
    return r;
  endfunction

  function automatic bit is_illegal(logic [1:0] dt, logic [7:0] a);
    return (dt == 2'd3) || (dt == 2'd1 && a % 2 != 0) || (dt == 2'd2 && a % 4 != 0);
  endfunction

  function automatic int nbytes(logic [1:0] dt);
    return (dt == 2'd0) ? 1 : (dt == 2'd1) ? 2 : 4;
  endfunction

  always @(negedge clk) begin : cmp
    exp_t e;
    if (chk_en) begin
      if (expq.size() > 0) e = expq.pop_front();
      else e = mk(1'b0, 1'b0, 1'b0, 1'b0, model_addr, 8'h00, 1'b1, model_rdata);
      chk("busy",     32'(bus.busy),     32'(e.busy));
      chk("moc",      32'(bus.moc),      32'(e.moc));
      chk("err",      32'(bus.err),      32'(e.err));
      chk("mem_we",   32'(bus.mem_we),   32'(e.we));
      chk("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
      chk("rdata",    bus.rdata,         e.rdata);
      if (e.wchk) chk("mem_wdata", 32'(bus.mem_wdata), 32'(e.wdata));
    end
  end

  // Expected timeline of one accepted request, one entry per cycle after accept.
  task automatic push_expect(input bit rw, input logic [1:0] dt, input logic [7:0] a,
                             input logic [31:0] wd);
    int          n;
    logic [31:0] val;
    if (is_illegal(dt, a)) begin
      expq.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, a, 8'h00, 1'b1, model_rdata));
    end else begin
      n = nbytes(dt);
      val = '0;
      for (int i = 0; i < n; i++) val = (val << 8) | 32'(ref_mem[8'(a + i)]);
      for (int k = 0; k < n; k++)
        expq.push_back(mk(1'b1, 1'b0, 1'b0, !rw, 8'(a + k),
                          rw ? 8'h00 : 8'(wd >> (8 * (n - 1 - k))), !rw, model_rdata));
      if (rw) model_rdata = val;
      expq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, a, 8'h00, 1'b1, model_rdata));
    end
    model_addr = a;
  endtask

  task automatic access(input bit rw, input logic [1:0] dt, input logic [7:0] a,
                        input logic [31:0] wd, input bit noise, input bit hold,
                        input bit skip_neg, output int moc_cyc);
    int L;
    int n;
    if (!skip_neg) @(negedge clk);
    bus.req = 1'b1; bus.r_w = rw; bus.dt = dt; bus.addr = a; bus.wdata = wd;
    @(posedge clk);
    push_expect(rw, dt, a, wd);
    n = nbytes(dt);
    if (!is_illegal(dt, a) && !rw)
      for (int i = 0; i < n; i++) ref_mem[8'(a + i)] = 8'(wd >> (8 * (n - 1 - i)));
    L = is_illegal(dt, a) ? 1 : n + 1;
    moc_cyc = 0;
    for (int i = 1; i <= L; i++) begin
      @(negedge clk);
      if (bus.moc === 1'b1 && moc_cyc == 0) moc_cyc = i;
      if (i == L) bus.req = hold;
      else        bus.req = noise;
      if (noise) begin
        bus.r_w = 1'($urandom); bus.dt = 2'($urandom);
        bus.addr = 8'($urandom); bus.wdata = $urandom;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.req = 1'b0; bus.addr = 8'($urandom); bus.wdata = $urandom;
    end
  endtask

  initial begin
    int mc;
    bit rw, noise, hold;
    logic [1:0] dt;
    logic [7:0] a;
    logic [31:0] wd;

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 5);
    bus.req = 1'b1; bus.r_w = 1'b1; bus.dt = 2'd0; bus.addr = 8'h05; bus.wdata = '0;
    #1 clr = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_busy",     32'(bus.busy),     32'h0);
      chk("rst_moc",      32'(bus.moc),      32'h0);
      chk("rst_mem_we",   32'(bus.mem_we),   32'h0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
      chk("rst_rdata",    bus.rdata,         32'h0);
    end
    mem_init = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    chk_en = 1'b1;
    access(1'b1, 2'd0, 8'h05, 32'h0, 1'b0, 1'b0, 1'b1, mc);
    chk("first_read", bus.rdata, 32'h000000BE);
    chk("byte_lat", 32'(mc), 32'd2);

    access(1'b0, 2'd2, 8'h10, 32'hA1B2C3D4, 1'b0, 1'b0, 1'b0, mc);
    chk("wr_10", 32'(mem[8'h10]), 32'hA1);
    chk("wr_11", 32'(mem[8'h11]), 32'hB2);
    chk("wr_12", 32'(mem[8'h12]), 32'hC3);
    chk("wr_13", 32'(mem[8'h13]), 32'hD4);
    access(1'b1, 2'd2, 8'h10, 32'h0, 1'b0, 1'b0, 1'b0, mc);
    chk("word_read", bus.rdata, 32'hA1B2C3D4);
    chk("word_lat", 32'(mc), 32'd5);

    access(1'b0, 2'd1, 8'h20, 32'h0000807F, 1'b0, 1'b0, 1'b0, mc);
    access(1'b1, 2'd1, 8'h20, 32'h0, 1'b0, 1'b0, 1'b0, mc);
    chk("half_read", bus.rdata, 32'h0000807F);
    access(1'b1, 2'd0, 8'h21, 32'h0, 1'b0, 1'b0, 1'b0, mc);
    chk("byte_read", bus.rdata, 32'h0000007F);
    chk("byte_read_lat", 32'(mc), 32'd2);

    access(1'b1, 2'd2, 8'h12, 32'h0, 1'b0, 1'b0, 1'b0, mc);
    chk("misalign_moc", 32'(bus.moc), 32'h1);
    chk("misalign_err", 32'(bus.err), 32'h1);
    chk("misalign_lat", 32'(mc), 32'd1);
    access(1'b0, 2'd3, 8'h00, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, mc);
    chk("dt3_err", 32'(bus.err), 32'h1);
    chk("dt3_rdata", bus.rdata, 32'h0000007F);

    access(1'b0, 2'd2, 8'hFC, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, mc);
    chk("top_fc", 32'(mem[8'hFC]), 32'hDE);
    chk("top_fd", 32'(mem[8'hFD]), 32'hAD);
    chk("top_fe", 32'(mem[8'hFE]), 32'hBE);
    chk("top_ff", 32'(mem[8'hFF]), 32'hEF);
    chk("top_00", 32'(mem[8'h00]), 32'h05);

    @(negedge clk);
    bus.req = 1'b1; bus.r_w = 1'b0; bus.dt = 2'd2; bus.addr = 8'h40; bus.wdata = 32'h11223344;
    @(posedge clk);
    push_expect(1'b0, 2'd2, 8'h40, 32'h11223344);
    @(negedge clk);
    bus.req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_en = 1'b0;
    expq.delete();
    clr = 1'b0;
    bus.req = 1'b1;
    #1;
    chk("abort_mem_we",    32'(bus.mem_we),    32'h0);
    chk("abort_busy",      32'(bus.busy),      32'h0);
    chk("abort_moc",       32'(bus.moc),       32'h0);
    chk("abort_err",       32'(bus.err),       32'h0);
    chk("abort_mem_addr",  32'(bus.mem_addr),  32'h0);
    chk("abort_mem_wdata", 32'(bus.mem_wdata), 32'h0);
    chk("abort_rdata",     bus.rdata,          32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_hold_busy", 32'(bus.busy), 32'h0);
    ref_mem[8'h40] = 8'h11;
    ref_mem[8'h41] = 8'h22;
    model_addr = '0;
    model_rdata = '0;
    clr = 1'b1;
    bus.req = 1'b0;
    chk_en = 1'b1;
    chk("abort_40", 32'(mem[8'h40]), 32'h11);
    chk("abort_41", 32'(mem[8'h41]), 32'h22);
    chk("abort_42", 32'(mem[8'h42]), 32'h8F);
    chk("abort_43", 32'(mem[8'h43]), 32'hB4);

    access(1'b0, 2'd0, 8'h50, 32'h0000005A, 1'b1, 1'b1, 1'b0, mc);
    chk("busy_req_one_moc", 32'(mc), 32'd2);
    access(1'b1, 2'd0, 8'h50, 32'h0, 1'b0, 1'b0, 1'b0, mc);
    chk("held_req_read", bus.rdata, 32'h0000005A);

    for (int t = 0; t < 150; t++) begin
      rw = 1'($urandom);
      dt = 2'($urandom);
      a  = 8'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (dt == 2'd1) a[0] = 1'b0;
        if (dt == 2'd2) a[1:0] = 2'b00;
      end
      wd    = $urandom;
      noise = 1'($urandom);
      hold  = 1'($urandom);
      access(rw, dt, a, wd, noise, hold, 1'b0, mc);
      if (!hold) idle($urandom_range(0, 2));
    end
    idle(3);

    for (int i = 0; i < 256; i++) chk("mem_final", 32'(mem[i]), 32'(ref_mem[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and clr.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 clr  input  1  asynchronous active-low reset.
REQ-004 req  input  1  access request (MOV strobe from the control unit), sampled only in IDLE.
REQ-005 r_w  input  1  1 = read, 0 = write.
REQ-006 dt  input  2  size: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
REQ-007 addr  input  8  byte address (MAR output).
REQ-008 wdata  input  32  write data (MDR output); the used bytes are right-justified.
REQ-009 rdata  output  32  read result, zero-extended and right-justified.
REQ-010 moc  output  1  memory-operation-complete pulse, 1 cycle wide.
REQ-011 busy  output  1  high from the accept edge until the end of the DONE cycle.
REQ-012 err  output  1  error flag, valid with moc.
REQ-013 mem_addr  output  8  byte address to the 256x8 storage array.
REQ-014 mem_wdata  output  8  byte to write.
REQ-015 mem_we  output  1  byte write enable; the array writes on the rising clk edge while this is high.
REQ-016 mem_rdata  input  8  combinational read byte at mem_addr.

Function
REQ-017 The states SHALL be IDLE, XFER and DONE, with a 2-bit byte counter cnt and a latched copy of r_w, dt, addr and wdata.
REQ-018 In IDLE with req=1, the rising edge SHALL latch the request and go to XFER with cnt=0; if the request is illegal, it SHALL instead go to DONE with the error pending.
REQ-019 A request SHALL be illegal when dt=11, when dt=01 and addr[0]=1, or when dt=10 and addr[1:0]!=00.
REQ-020 An illegal request SHALL never assert mem_we and SHALL leave rdata unchanged.
REQ-021 The byte count N SHALL be 1, 2 or 4 for byte, halfword or word; in XFER, mem_addr SHALL equal the latched addr+cnt (8-bit).
REQ-022 Alignment SHALL guarantee that no access wraps past address 255.
REQ-023 Byte order SHALL be big-endian: the byte at the lowest address is the most significant of the N bytes.
REQ-024 For a write, XFER cycle k SHALL drive mem_we=1 and mem_wdata = byte (N-1-k) of the latched wdata, where byte 0 is bits [7:0].
REQ-025 For a read, XFER cycle k SHALL keep mem_we=0 and capture mem_rdata into byte (N-1-k) of an internal accumulator.
REQ-026 The accumulator SHALL be cleared at accept, so unused upper bytes read as 0.
REQ-027 On the edge ending XFER cycle cnt=N-1, the block SHALL go to DONE; for reads, rdata SHALL update on this same edge.
REQ-028 In DONE, moc SHALL be 1 and err SHALL be 1 for an illegal request or 0 otherwise; the next edge SHALL return to IDLE.
REQ-029 Latency SHALL be N+1 cycles from the accept edge to the end of moc, and 1 cycle for an illegal request.
REQ-030 req asserted while busy=1 SHALL be ignored and SHALL not be queued.
REQ-031 req held high through DONE SHALL be accepted again on the first IDLE edge, giving back-to-back accesses with one IDLE cycle between them.
REQ-032 rdata SHALL hold its value until the next completed legal read; writes and errors SHALL not alter it.
REQ-033 Outside XFER: mem_we=0, mem_wdata=0, and mem_addr = the latched addr.
REQ-034 mem_we SHALL be driven directly from the registered state so that it is glitch-free.

Reset
REQ-035 clr=0 SHALL immediately force IDLE, cnt=0, rdata=0, moc=0, busy=0, err=0, mem_we=0, mem_wdata=0, mem_addr=0, and clear all latched request fields.
REQ-036 A reset during XFER SHALL abort the access; bytes already written SHALL remain in the array; no moc SHALL be produced for the aborted access.
REQ-037 The first request SHALL be accepted only on the first rising edge with clr=1 and req=1.

Verification
REQ-038 Word write then word read: write addr=0x10, wdata=0xA1B2C3D4, then read addr=0x10 -> the write puts bytes 0x10..0x13 = A1,B2,C3,D4 over 4 mem_we cycles; the read gives rdata=0xA1B2C3D4, moc on cycle 5 after accept, err=0.
REQ-039 Halfword and byte reads: array bytes 0x20=0x80, 0x21=0x7F -> dt=01 at addr 0x20 gives rdata=0x0000807F; dt=00 at addr 0x21 gives rdata=0x0000007F with moc 2 cycles after accept.
REQ-040 Misalignment: dt=10 at addr=0x12 and dt=11 at addr=0x00 -> each gives moc=1 and err=1 on the cycle after accept; mem_we is never asserted; rdata is unchanged.
REQ-041 Top of memory: dt=10 write of 0xDEADBEEF at addr=0xFC -> bytes 0xFC..0xFF = DE,AD,BE,EF, and address 0x00 is untouched.
REQ-042 Reset mid-write: clr pulled low after 2 of 4 write cycles at addr 0x40 -> mem_we drops immediately; bytes 0x40..0x41 are written and 0x42..0x43 keep their old values; no moc; all outputs are 0.
REQ-043 Request while busy: req pulses during XFER of a byte write -> it is ignored; exactly one moc; a held req is accepted on the edge after DONE.
